// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
//
// Round-robin arbiter and sequencer that lets NUM_REQ client blocks share one
// serial transmit FSM. One requester's word is captured at a time, presented on
// `data`, launched with a single-cycle `tx` pulse, and then the FSM's `busy`
// handshake is tracked until the transfer completes.
//
// Handshakes:
//   req/ack : a requester raises req[i] with a stable word on its req_data
//             slice and holds both until ack[i] pulses for one cycle; the
//             word is captured on the same edge that raises ack[i].
//   tx/busy : tx pulses for one cycle with `data` already valid; the FSM
//             raises `busy` (possibly in the very first cycle after tx) and
//             drops it when transmission ends; `done` pulses in the cycle
//             after `busy` is seen low again.
//
// Parameters:
//   NUM_REQ      number of requesters (2..8)
//   DATA_W       width of each requester word and of `data`
//   BUSY_TIMEOUT cycles to wait in WAIT_BUSY before giving up (timeout build)
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   req          per-requester request vector
//   req_data     packed requester words, requester i at [i*DATA_W +: DATA_W]
//   ack          one-hot, one-cycle capture acknowledge
//   busy         transmit FSM busy flag
//   tx           one-cycle start pulse to the transmit FSM
//   data         word to the transmit FSM, stable from tx until back in IDLE
//   owner        index of the current/last granted requester
//   active       high in every state except IDLE
//   done         one-cycle pulse when a transfer completes
//   timeout_err  one-cycle pulse when busy never rose (timeout build only)
//   dbg_state    current FSM state (IDLE=0, LAUNCH=1, WAIT_BUSY=2, WAIT_DONE=3)
//
// Build option:
//   TX_ARB_TIMEOUT_EN  when defined, WAIT_BUSY gives up after BUSY_TIMEOUT
//                      cycles without `busy` and pulses timeout_err. When
//                      undefined, WAIT_BUSY waits for `busy` indefinitely and
//                      the timeout_err port does not exist.
// -----------------------------------------------------------------------------
module tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 3,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  input  logic                       busy,
  output logic                       tx,
  output logic [DATA_W-1:0]          data,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       active,
  output logic                       done,
`ifdef TX_ARB_TIMEOUT_EN
  output logic                       timeout_err,
`endif
  output logic [1:0]                 dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Marker scope that only elaborates for an unsupported configuration, so a
  // bad parameter set is visible in any hierarchy listing.
  if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_TIMEOUT < 1) begin : g_param_range_violation
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 tx_q, tx_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
`endif

  // ---------------------------------------------------------------------------
  // Unpack requester words
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] words [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign words[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // ---------------------------------------------------------------------------
  // Round-robin winner: scan upward from the index after the last grant,
  // wrapping at NUM_REQ. The first set request in scan order wins.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] winner;

  always_comb begin : p_arb
    logic             found;
    logic [IDX_W-1:0] idx;
    found  = 1'b0;
    idx    = '0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tx_d    = 1'b0;
    ack_d   = '0;
    data_d  = data_q;
    owner_d = owner_q;
    done_d  = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = LAUNCH;
          tx_d    = 1'b1;
          ack_d   = NUM_REQ'(1) << winner;
          data_d  = words[winner];
          owner_d = winner;
          ptr_d   = winner;
        end
      end

      LAUNCH: begin
        state_d = WAIT_BUSY;
`ifdef TX_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end

      WAIT_BUSY: begin
        if (busy) begin
          state_d = WAIT_DONE;
`ifdef TX_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // This was the last allowed cycle without busy; give up. The
          // pointer already moved at grant time, so fairness is kept.
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      WAIT_DONE: begin
        if (!busy) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered version of "not IDLE", aligned with the state register.
    active_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      // Pointing at the last index makes requester 0 first in scan order.
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      tx_q     <= 1'b0;
      ack_q    <= '0;
      data_q   <= '0;
      owner_q  <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      tx_q     <= tx_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      owner_q  <= owner_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`endif

  assign tx        = tx_q;
  assign ack       = ack_q;
  assign data      = data_q;
  assign owner     = owner_q;
  assign active    = active_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_arbiter
//
// Directed phases plus a randomized phase. Each clock, a transaction-level
// reference (who is free, who wins by round-robin, when the transfer must
// complete given the busy profile the bench itself drives) predicts every
// output, and immediate assertions compare.
// -----------------------------------------------------------------------------
module tb_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int DATA_W       = 3;
  localparam int BUSY_TIMEOUT = 15;
  localparam int IDX_W        = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic                      busy = 1'b0;
  logic [NUM_REQ-1:0]        ack;
  logic                      tx;
  logic [DATA_W-1:0]         data;
  logic [IDX_W-1:0]          owner;
  logic                      active;
  logic                      done;
  logic [1:0]                dbg_state;
`ifdef TX_ARB_TIMEOUT_EN
  logic                      timeout_err;
`endif

  always #5 clk = ~clk;

  tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W(DATA_W),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .busy(busy),
    .tx(tx),
    .data(data),
    .owner(owner),
    .active(active),
    .done(done),
`ifdef TX_ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit                m_free = 1'b1;   // arbiter idle and able to grant
  int                m_ptr  = NUM_REQ - 1;
  logic [DATA_W-1:0] m_data = '0;
  int                m_owner = 0;
  int                done_at = -1;
  int                timeout_at = -1;
  int                b_start = -1;
  int                b_end = -2;

  bit hold [NUM_REQ];
  bit rand_req   = 1'b0;
  bit busy_never = 1'b0;
  int d_lo = 0, d_hi = 0, h_lo = 1, h_hi = 1;

  int grant_q  [$];
  int tx_cyc_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  // One clock: advance, predict, compare, then drive inputs for the next edge.
  task automatic tick();
    logic [NUM_REQ-1:0]        p_req;
    logic [NUM_REQ*DATA_W-1:0] p_data;
    logic                      p_reset;
    logic                      exp_tx;
    logic                      exp_done;
    logic [NUM_REQ-1:0]        exp_ack;
    int                        w;
`ifdef TX_ARB_TIMEOUT_EN
    logic                      exp_to;
    exp_to = 1'b0;
`endif
    p_req   = req;
    p_data  = req_data;
    p_reset = reset;
    @(posedge clk);
    #1;
    cyc++;
    exp_tx   = 1'b0;
    exp_done = 1'b0;
    exp_ack  = '0;
    if (p_reset) begin
      m_free = 1'b1; m_ptr = NUM_REQ - 1; m_data = '0; m_owner = 0;
      done_at = -1; timeout_at = -1; b_start = -1; b_end = -2;
    end else begin
      if (m_free && p_req != '0) begin
        w = rr_pick(p_req, m_ptr);
        exp_tx     = 1'b1;
        exp_ack[w] = 1'b1;
        m_data     = p_data[w*DATA_W +: DATA_W];
        m_owner    = w;
        m_ptr      = w;
        m_free     = 1'b0;
        grant_q.push_back(w);
        tx_cyc_q.push_back(cyc);
        if (busy_never) begin
          b_start = -1; b_end = -2; done_at = -1;
          timeout_at = cyc + 1 + BUSY_TIMEOUT;
        end else begin
          b_start = cyc + 1 + int'($urandom_range(d_lo, d_hi));
          b_end   = b_start + int'($urandom_range(h_lo, h_hi)) - 1;
          done_at = b_end + 2;   // done in the cycle after busy is seen low
          timeout_at = -1;
        end
      end
      if (cyc == done_at) begin
        exp_done = 1'b1;
        m_free   = 1'b1;
      end
      if (cyc == timeout_at) begin
`ifdef TX_ARB_TIMEOUT_EN
        exp_to = 1'b1;
`endif
        m_free = 1'b1;
      end
    end
    chk("tx", tx, exp_tx);
    chk("ack", ack, exp_ack);
    chk("data", data, m_data);
    chk("owner", owner, m_owner);
    chk("active", active, !m_free);
    chk("done", done, exp_done);
`ifdef TX_ARB_TIMEOUT_EN
    chk("timeout_err", timeout_err, exp_to);
`endif
    // Requesters: drop after their grant unless holding; optionally re-request.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_ack[i]) begin
        if (!hold[i]) req[i] = 1'b0;
      end else if (rand_req && !req[i] && $urandom_range(0, 3) == 0) begin
        req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        req[i] = 1'b1;
      end
    end
    busy = (cyc >= b_start && cyc <= b_end);
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (!(req == '0 && m_free) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, (req == '0 && m_free), 1);
  endtask

  task automatic wait_grants(input int cnt, input int budget, input string tag);
    int n = 0;
    while (grant_q.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    chk(tag, grant_q.size() >= cnt, 1);
  endtask

  task automatic wait_cycle(input int target, input int budget, input string tag);
    int n = 0;
    while (cyc < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, cyc >= target, 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    int rst_tx_cyc;
    for (int i = 0; i < NUM_REQ; i++) hold[i] = 1'b0;

    // Reset then idle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_state", dbg_state, 0);
    repeat (10) tick();

    // Single transfer from requester 2, busy 2 cycles after tx for 3 cycles
    grant_q.delete();
    req_data[2*DATA_W +: DATA_W] = 3'b101;
    req = 4'b0100;
    d_lo = 1; d_hi = 1; h_lo = 3; h_hi = 3;
    repeat (10) tick();
    chk("single_count", grant_q.size(), 1);
    chk("single_owner", (grant_q.size() > 0) ? grant_q[0] : -1, 2);
    chk("single_data", data, 3'b101);

    // Round-robin from a fresh reset: all four requesting
    reset = 1'b1;
    tick();
    reset = 1'b0;
    grant_q.delete();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    req = 4'b1111;
    d_lo = 0; d_hi = 0; h_lo = 2; h_hi = 2;
    wait_grants(4, 40, "rr_timeout");
    for (int i = 0; i < 4; i++)
      chk("rr_order", (grant_q.size() > i) ? grant_q[i] : -1, i);
    drain(20, "rr_drain");

    // Wrap: after owner 3, request 0 and 3 -> 0 then 3
    grant_q.delete();
    req = 4'b1001;
    wait_grants(2, 30, "wrap_timeout");
    chk("wrap_first", (grant_q.size() > 0) ? grant_q[0] : -1, 0);
    chk("wrap_second", (grant_q.size() > 1) ? grant_q[1] : -1, 3);
    drain(20, "wrap_drain");

    // Back-to-back: requester 1 holds req, busy one cycle
    grant_q.delete();
    tx_cyc_q.delete();
    hold[1] = 1'b1;
    req_data[1*DATA_W +: DATA_W] = 3'b011;
    req = 4'b0010;
    d_lo = 0; d_hi = 0; h_lo = 1; h_hi = 1;
    repeat (17) tick();
    chk("b2b_count", tx_cyc_q.size(), 5);
    for (int i = 1; i < tx_cyc_q.size(); i++)
      chk("b2b_spacing", tx_cyc_q[i] - tx_cyc_q[i-1], 4);
    foreach (grant_q[i]) chk("b2b_owner", grant_q[i], 1);
    hold[1] = 1'b0;
    drain(20, "b2b_drain");

    // Reset in WAIT_DONE with busy high; pending req[0] must win afterwards
    grant_q.delete();
    req_data[2*DATA_W +: DATA_W] = DATA_W'($urandom);
    req = 4'b0100;
    d_lo = 0; d_hi = 0; h_lo = 6; h_hi = 6;
    wait_grants(1, 10, "mid_tx_timeout");
    rst_tx_cyc = (tx_cyc_q.size() > 0) ? tx_cyc_q[$] : cyc;
    req[0] = 1'b1;
    req[3] = 1'b1;
    wait_cycle(rst_tx_cyc + 3, 10, "mid_reach_wait_done");
    chk("mid_busy_high", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_state", dbg_state, 0);
    chk("mid_rst_tx", tx, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_active", active, 0);
    grant_q.delete();
    d_lo = 0; d_hi = 2; h_lo = 1; h_hi = 3;
    wait_grants(1, 5, "post_rst_timeout");
    chk("post_rst_first", (grant_q.size() > 0) ? grant_q[0] : -1, 0);
    drain(40, "post_rst_drain");

    // Randomized traffic with random busy profiles
    rand_req = 1'b1;
    d_lo = 0; d_hi = 3; h_lo = 1; h_hi = 4;
    repeat (400) tick();
    rand_req = 1'b0;
    drain(200, "rand_drain");

`ifdef TX_ARB_TIMEOUT_EN
    // Busy never rises: timeout_err, no done, then a normal transfer
    grant_q.delete();
    busy_never = 1'b1;
    req = 4'b0010;
    wait_grants(1, 10, "to_grant");
    busy_never = 1'b0;
    d_lo = 0; d_hi = 0; h_lo = 1; h_hi = 1;
    repeat (BUSY_TIMEOUT + 2) tick();
    req = 4'b0100;
    wait_grants(2, 10, "to_next_grant");
    chk("to_next_owner", (grant_q.size() > 1) ? grant_q[1] : -1, 2);
    drain(20, "to_drain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
